// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the skid-buffered pipeline register: FSM state encoding
// and the stall-event decode used by the stall counter.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } skid_state_e;

    function automatic logic stall_event(input logic valid, input logic ready);
        return valid & ~ready;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding register: value payload plus control payload, with load
// and a control-only clear so a bubble keeps its data but carries no side effects.
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clr_ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            ctrl_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            ctrl_q <= ctrl_i;
        end else if (clr_ctrl_i) begin
            ctrl_q <= '0;
        end
    end

    assign data_o = data_q;
    assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, one-entry skid buffer,
// flush squash and a saturating back-pressure cycle counter.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stall_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    skid_state_e       state_q, state_d;
    logic              m_load, m_clr, s_load, s_clr;
    logic [DATA_W-1:0] m_src_data, s_data;
    logic [CTRL_W-1:0] m_src_ctrl, s_ctrl;
    logic [CNT_W-1:0]  stall_q, stall_d;

    // Ready depends only on the state flop (and reset), never on out_ready.
    assign in_ready  = ~rst & (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);

    // Main slot refills from the skid slot when draining, otherwise from upstream.
    assign m_src_data = (state_q == ST_SKID) ? s_data : in_data;
    assign m_src_ctrl = (state_q == ST_SKID) ? s_ctrl : in_ctrl;

    always_comb begin
        state_d = state_q;
        m_load  = 1'b0;
        m_clr   = 1'b0;
        s_load  = 1'b0;
        s_clr   = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
            m_clr   = 1'b1;
            s_clr   = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        m_load  = 1'b1;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            m_load = 1'b1;
                        end else begin
                            m_clr   = 1'b1;
                            state_d = ST_EMPTY;
                        end
                    end else if (in_valid) begin
                        s_load  = 1'b1;
                        state_d = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        m_load  = 1'b1;
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    m_clr   = 1'b1;
                    s_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall counter: clear wins over increment; flush leaves it untouched.
    always_comb begin
        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = '0;
        end else if (stall_event(out_valid, out_ready) && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk        (clk),
        .rst        (rst),
        .load_i     (m_load),
        .clr_ctrl_i (m_clr),
        .data_i     (m_src_data),
        .ctrl_i     (m_src_ctrl),
        .data_o     (out_data),
        .ctrl_o     (out_ctrl)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load_i     (s_load),
        .clr_ctrl_i (s_clr),
        .data_i     (in_data),
        .ctrl_i     (in_ctrl),
        .data_o     (s_data),
        .ctrl_o     (s_ctrl)
    );

endmodule
